// File: rtl/dx_stage_pkg.sv
// Shared ISA definitions and decode helper for the decode-to-execute stage.
// Opcode and multdiv ALU-op codes are also used by fetch/decode and X.
package dx_stage_pkg;

   localparam logic [4:0] OpRtype = 5'b00000;
   localparam logic [4:0] OpJ     = 5'b00001;
   localparam logic [4:0] OpBne   = 5'b00010;
   localparam logic [4:0] OpJal   = 5'b00011;
   localparam logic [4:0] OpJr    = 5'b00100;
   localparam logic [4:0] OpAddi  = 5'b00101;
   localparam logic [4:0] OpBlt   = 5'b00110;
   localparam logic [4:0] OpSw    = 5'b00111;
   localparam logic [4:0] OpLw    = 5'b01000;
   localparam logic [4:0] OpSetx  = 5'b10101;
   localparam logic [4:0] OpBex   = 5'b10110;

   localparam logic [4:0] AluMult = 5'b00110;
   localparam logic [4:0] AluDiv  = 5'b00111;

   typedef struct packed {
      logic rtype;
      logic addi;
      logic lw;
      logic sw;
      logic branch;
      logic jr;
      logic bex;
      logic valid;
   } dx_flags_t;

   typedef struct packed {
      dx_flags_t flags;
      logic      use_a;
      logic      use_b;
      logic      b_from_rd;
      logic      a_status;
   } decode_t;

   function automatic decode_t decode(input logic [4:0] op);
      decode_t d;
      d = '0;
      d.flags.valid = 1'b1;
      unique case (op)
         OpRtype: begin
            d.flags.rtype = 1'b1;
            d.use_a       = 1'b1;
            d.use_b       = 1'b1;
         end
         OpJ, OpJal, OpSetx: ;
         OpBne, OpBlt: begin
            d.flags.branch = 1'b1;
            d.use_a        = 1'b1;
            d.use_b        = 1'b1;
            d.b_from_rd    = 1'b1;
         end
         OpJr: begin
            d.flags.jr  = 1'b1;
            d.use_b     = 1'b1;
            d.b_from_rd = 1'b1;
         end
         OpAddi: begin
            d.flags.addi = 1'b1;
            d.use_a      = 1'b1;
         end
         OpSw: begin
            d.flags.sw  = 1'b1;
            d.use_a     = 1'b1;
            d.use_b     = 1'b1;
            d.b_from_rd = 1'b1;
         end
         OpLw: begin
            d.flags.lw = 1'b1;
            d.use_a    = 1'b1;
         end
         OpBex: begin
            d.flags.bex = 1'b1;
            d.use_a     = 1'b1;
            d.a_status  = 1'b1;
         end
         // Undefined opcodes still occupy the slot but read nothing.
         default: ;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/dx_stage_register.sv
// Enabled register with asynchronous active-high reset to a configurable value.
module dx_stage_register #(
   parameter int unsigned      Width    = 32,
   parameter logic [Width-1:0] ResetVal = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [Width-1:0] d,
   output logic [Width-1:0] q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= ResetVal;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/dx_stage.sv
// Decode-to-execute stage: register read addressing, load-use detection,
// bubble insertion on hazards/flushes and hold while multdiv is busy.
module dx_stage
   import dx_stage_pkg::*;
#(
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
   parameter logic [4:0]  RSTATUS   = 5'd30
) (
   input  logic        rise,
   input  logic        reset,
   input  logic [31:0] pc_fd,
   input  logic [31:0] instr_fd,
   input  logic [31:0] rdata_a,
   input  logic [31:0] rdata_b,
   input  logic        flush_dx,
   input  logic        md_busy,
   output logic [4:0]  raddr_a,
   output logic [4:0]  raddr_b,
   output logic        stall_fd,
   output logic [31:0] pc_dx,
   output logic [31:0] instr_dx,
   output logic [31:0] a_dx,
   output logic [31:0] b_dx,
   output logic [4:0]  rd_dx,
   output logic        rtype_dx,
   output logic        addi_dx,
   output logic        lw_dx,
   output logic        sw_dx,
   output logic        branch_dx,
   output logic        jr_dx,
   output logic        bex_dx,
   output logic        valid_dx,
   output logic [15:0] bubble_count
);

   decode_t   dec;
   dx_flags_t flags_q;
   dx_flags_t flags_d;
   logic      lu;
   logic      load_en;
   logic      bubble;
   logic [31:0] pc_d, instr_d, a_d, b_d;
   logic [15:0] bubble_count_d, bubble_count_q;

   assign dec = decode(instr_fd[31:27]);

   assign raddr_a = dec.a_status  ? RSTATUS         : instr_fd[21:17];
   assign raddr_b = dec.b_from_rd ? instr_fd[26:22] : instr_fd[16:12];

   assign rd_dx = instr_dx[26:22];

   assign lu = flags_q.lw && flags_q.valid && (rd_dx != 5'd0) &&
               ((dec.use_a && (rd_dx == raddr_a)) || (dec.use_b && (rd_dx == raddr_b)));

   assign stall_fd = lu | md_busy;

   // Flush outranks the multdiv hold; a held stage never evaluates lu.
   assign load_en = flush_dx | ~md_busy;
   assign bubble  = load_en & (flush_dx | lu);

   always_comb begin
      pc_d    = pc_fd;
      instr_d = instr_fd;
      a_d     = rdata_a;
      b_d     = rdata_b;
      flags_d = dec.flags;
      if (bubble) begin
         pc_d    = 32'd0;
         instr_d = NOP_INSTR;
         a_d     = 32'd0;
         b_d     = 32'd0;
         flags_d = '0;
      end
   end

   dx_stage_register #(.Width(32), .ResetVal(32'd0)) u_pc_reg (
      .clk (rise),
      .rst (reset),
      .en  (load_en),
      .d   (pc_d),
      .q   (pc_dx)
   );

   dx_stage_register #(.Width(32), .ResetVal(NOP_INSTR)) u_instr_reg (
      .clk (rise),
      .rst (reset),
      .en  (load_en),
      .d   (instr_d),
      .q   (instr_dx)
   );

   dx_stage_register #(.Width(32), .ResetVal(32'd0)) u_a_reg (
      .clk (rise),
      .rst (reset),
      .en  (load_en),
      .d   (a_d),
      .q   (a_dx)
   );

   dx_stage_register #(.Width(32), .ResetVal(32'd0)) u_b_reg (
      .clk (rise),
      .rst (reset),
      .en  (load_en),
      .d   (b_d),
      .q   (b_dx)
   );

   dx_stage_register #(.Width($bits(dx_flags_t)), .ResetVal('0)) u_flags_reg (
      .clk (rise),
      .rst (reset),
      .en  (load_en),
      .d   (flags_d),
      .q   (flags_q)
   );

   assign rtype_dx  = flags_q.rtype;
   assign addi_dx   = flags_q.addi;
   assign lw_dx     = flags_q.lw;
   assign sw_dx     = flags_q.sw;
   assign branch_dx = flags_q.branch;
   assign jr_dx     = flags_q.jr;
   assign bex_dx    = flags_q.bex;
   assign valid_dx  = flags_q.valid;

   always_comb begin
      bubble_count_d = bubble_count_q;
      if (bubble && (bubble_count_q != 16'hFFFF)) begin
         bubble_count_d = bubble_count_q + 16'd1;
      end
   end

   always_ff @(posedge rise or posedge reset) begin
      if (reset) begin
         bubble_count_q <= 16'd0;
      end else begin
         bubble_count_q <= bubble_count_d;
      end
   end

   assign bubble_count = bubble_count_q;

endmodule

// File: tb/tb_dx_stage.sv
// Scoreboard bench for dx_stage: stimulus pushes expected DX state per edge,
// a monitor pops and compares after each rising edge.
module tb_dx_stage;

   localparam logic [1:0] KLoad = 2'd0;
   localparam logic [1:0] KBub  = 2'd1;
   localparam logic [1:0] KHold = 2'd2;

   localparam logic [7:0] FLw   = 8'b0010_0001;
   localparam logic [7:0] FR    = 8'b1000_0001;
   localparam logic [7:0] FJ    = 8'b0000_0001;
   localparam logic [7:0] FBr   = 8'b0000_1001;
   localparam logic [7:0] FAddi = 8'b0100_0001;
   localparam logic [7:0] FBex  = 8'b0000_0011;
   localparam logic [7:0] FSw   = 8'b0001_0001;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic [7:0]  flags;
      logic [15:0] cnt;
   } exp_t;

   logic        rise = 1'b0;
   logic        reset;
   logic [31:0] pc_fd, instr_fd, rdata_a, rdata_b;
   logic        flush_dx, md_busy;
   logic [4:0]  raddr_a, raddr_b;
   logic        stall_fd;
   logic [31:0] pc_dx, instr_dx, a_dx, b_dx;
   logic [4:0]  rd_dx;
   logic        rtype_dx, addi_dx, lw_dx, sw_dx, branch_dx, jr_dx, bex_dx, valid_dx;
   logic [15:0] bubble_count;

   int total = 0;
   int bad   = 0;
   exp_t q[$];
   exp_t last;

   dx_stage u_dut (
      .rise         (rise),
      .reset        (reset),
      .pc_fd        (pc_fd),
      .instr_fd     (instr_fd),
      .rdata_a      (rdata_a),
      .rdata_b      (rdata_b),
      .flush_dx     (flush_dx),
      .md_busy      (md_busy),
      .raddr_a      (raddr_a),
      .raddr_b      (raddr_b),
      .stall_fd     (stall_fd),
      .pc_dx        (pc_dx),
      .instr_dx     (instr_dx),
      .a_dx         (a_dx),
      .b_dx         (b_dx),
      .rd_dx        (rd_dx),
      .rtype_dx     (rtype_dx),
      .addi_dx      (addi_dx),
      .lw_dx        (lw_dx),
      .sw_dx        (sw_dx),
      .branch_dx    (branch_dx),
      .jr_dx        (jr_dx),
      .bex_dx       (bex_dx),
      .valid_dx     (valid_dx),
      .bubble_count (bubble_count)
   );

   always #5 rise = ~rise;

   function automatic logic [31:0] enc_r(input logic [4:0] rd, rs, rt);
      return {5'b00000, rd, rs, rt, 12'd0};
   endfunction

   function automatic logic [31:0] enc_i(input logic [4:0] op, rd, rs, input logic [16:0] imm);
      return {op, rd, rs, imm};
   endfunction

   function automatic logic [31:0] enc_j(input logic [4:0] op, input logic [26:0] t);
      return {op, t};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] dut_flags();
      return {rtype_dx, addi_dx, lw_dx, sw_dx, branch_dx, jr_dx, bex_dx, valid_dx};
   endfunction

   task automatic chk_state(input string tag, input exp_t e);
      chk({tag, ".pc"},    pc_dx,        e.pc);
      chk({tag, ".instr"}, instr_dx,     e.instr);
      chk({tag, ".a"},     a_dx,         e.a);
      chk({tag, ".b"},     b_dx,         e.b);
      chk({tag, ".rd"},    32'(rd_dx),   32'(e.rd));
      chk({tag, ".flags"}, 32'(dut_flags()), 32'(e.flags));
      chk({tag, ".cnt"},   32'(bubble_count), 32'(e.cnt));
   endtask

   // Monitor: every rising edge presents a new DX state.
   always @(posedge rise) begin
      #1;
      if (q.size() != 0) chk_state("dx", q.pop_front());
   end

   // Drive one fetch/decode slot at a falling edge, check comb outputs, queue expected DX.
   task automatic step(input logic [31:0] pc, instr, input logic fl, md,
                       input logic [4:0] era, erb, input logic est,
                       input logic [1:0] kind, input logic [7:0] ef, input logic [15:0] ecnt);
      exp_t e;
      pc_fd    = pc;
      instr_fd = instr;
      rdata_a  = {16'hA5A5, pc[15:0]};
      rdata_b  = {16'h5A5A, pc[15:0]};
      flush_dx = fl;
      md_busy  = md;
      #1;
      chk("raddr_a", 32'(raddr_a), 32'(era));
      chk("raddr_b", 32'(raddr_b), 32'(erb));
      chk("stall_fd", 32'(stall_fd), 32'(est));
      if (kind == KLoad) begin
         e = '{pc: pc, instr: instr, a: rdata_a, b: rdata_b, rd: instr[26:22], flags: ef,
               cnt: ecnt};
      end else if (kind == KBub) begin
         e = '{pc: 32'd0, instr: 32'd0, a: 32'd0, b: 32'd0, rd: 5'd0, flags: 8'd0, cnt: ecnt};
      end else begin
         e = last;
         e.cnt = ecnt;
      end
      last = e;
      q.push_back(e);
      @(posedge rise);
      @(negedge rise);
   endtask

   initial begin
      exp_t zero;
      logic [31:0] add_656, bne_441, addi_713;
      zero = '0;
      add_656  = enc_r(5'd6, 5'd5, 5'd7);
      bne_441  = enc_i(5'b00010, 5'd4, 5'd1, 17'd8);
      addi_713 = enc_i(5'b00101, 5'd7, 5'd1, 17'd3);
      reset = 1'b1;
      pc_fd = 0; instr_fd = 0; rdata_a = 0; rdata_b = 0; flush_dx = 0; md_busy = 0;
      #3;
      chk_state("reset", zero);
      chk("reset.stall", 32'(stall_fd), 32'd0);
      @(negedge rise);
      reset = 1'b0;

      // Load-use: lw $5 then add $6,$5,$7 -> one bubble, add follows.
      step(32'h100, enc_i(5'b01000, 5'd5, 5'd2, 17'd0), 0, 0, 5'd2, 5'd0, 0, KLoad, FLw, 16'd0);
      step(32'h104, add_656, 0, 0, 5'd5, 5'd7, 1, KBub, 8'd0, 16'd1);
      step(32'h104, add_656, 0, 0, 5'd5, 5'd7, 0, KLoad, FR, 16'd1);
      // lw $0 never stalls.
      step(32'h108, enc_i(5'b01000, 5'd0, 5'd1, 17'd4), 0, 0, 5'd1, 5'd0, 0, KLoad, FLw, 16'd1);
      step(32'h10C, enc_r(5'd3, 5'd0, 5'd0), 0, 0, 5'd0, 5'd0, 0, KLoad, FR, 16'd1);
      // j whose rs field aliases $5 does not read it.
      step(32'h110, enc_i(5'b01000, 5'd5, 5'd2, 17'd0), 0, 0, 5'd2, 5'd0, 0, KLoad, FLw, 16'd1);
      step(32'h114, enc_j(5'b00001, 27'((5 << 17) | 100)), 0, 0, 5'd5, 5'd0, 0, KLoad, FJ,
           16'd1);
      // B-operand hazard through bne reading rd.
      step(32'h118, enc_i(5'b01000, 5'd4, 5'd3, 17'd0), 0, 0, 5'd3, 5'd0, 0, KLoad, FLw, 16'd1);
      step(32'h11C, bne_441, 0, 0, 5'd1, 5'd4, 1, KBub, 8'd0, 16'd2);
      step(32'h11C, bne_441, 0, 0, 5'd1, 5'd4, 0, KLoad, FBr, 16'd2);
      // Multdiv busy for three edges, then load.
      step(32'h120, addi_713, 0, 1, 5'd1, 5'd0, 1, KHold, 8'd0, 16'd2);
      step(32'h120, addi_713, 0, 1, 5'd1, 5'd0, 1, KHold, 8'd0, 16'd2);
      step(32'h120, addi_713, 0, 1, 5'd1, 5'd0, 1, KHold, 8'd0, 16'd2);
      step(32'h120, addi_713, 0, 0, 5'd1, 5'd0, 0, KLoad, FAddi, 16'd2);
      // Flush coinciding with load-use: a single bubble.
      step(32'h124, enc_i(5'b01000, 5'd9, 5'd1, 17'd0), 0, 0, 5'd1, 5'd0, 0, KLoad, FLw, 16'd2);
      step(32'h128, enc_r(5'd10, 5'd9, 5'd2), 1, 0, 5'd9, 5'd2, 1, KBub, 8'd0, 16'd3);
      step(32'h12C, enc_j(5'b10110, 27'h123), 0, 0, 5'd30, 5'd0, 0, KLoad, FBex, 16'd3);
      // Flush outranks multdiv hold.
      step(32'h130, addi_713, 1, 1, 5'd1, 5'd0, 1, KBub, 8'd0, 16'd4);
      step(32'h134, enc_i(5'b00111, 5'd2, 5'd3, 17'd4), 0, 0, 5'd3, 5'd2, 0, KLoad, FSw, 16'd4);
      step(32'h138, enc_i(5'b01000, 5'd5, 5'd1, 17'd0), 0, 0, 5'd1, 5'd0, 0, KLoad, FLw, 16'd4);

      // Asynchronous reset mid-cycle with a valid lw in DX and a pending hazard.
      instr_fd = add_656;
      pc_fd    = 32'h13C;
      #1;
      chk("pre_reset.stall", 32'(stall_fd), 32'd1);
      #1;
      reset = 1'b1;
      #1;
      chk_state("async_reset", zero);
      chk("async_reset.stall", 32'(stall_fd), 32'd0);
      @(posedge rise);
      #2;
      chk_state("held_reset", zero);
      chk("scoreboard_drained", 32'(q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
